// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers {addr, instr} pairs for decode, restarts on redirect.
// Latency: 1-cycle memory read plus 1-cycle queue write, so a request reaches out_valid two cycles after issue.
// Backpressure: fetch stalls when queued plus in-flight entries fill DEPTH; out_ready=0 holds the head entry stable.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       instr_rd_en,
   output logic [31:0]                instr_rd_addr,
   input  logic [31:0]                instr_rd_data,
   input  logic                       redirect,
   input  logic [31:0]                redirect_addr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [31:0]                out_addr,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]   r_pc;
   logic [31:0]   r_req_pc;
   logic          r_inflight;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_q_addr  [DEPTH];
   logic [31:0]   r_q_instr [DEPTH];

   logic [CW:0]   w_occupancy;
   logic [31:0]   w_redirect_pc;
   logic          w_fetch;
   logic          w_push;
   logic          w_pop;
   logic          w_has_data;

   // Slots already committed: queued entries plus the response still on its way back.
   // A pop this cycle is deliberately not counted, which keeps the issue decision off the out_ready path.
   assign w_occupancy   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_redirect_pc = redirect_addr & ~32'h3;

   assign w_fetch    = !rst && !redirect && (w_occupancy < (CW+1)'(DEPTH));
   assign w_has_data = (r_count != '0);
   assign w_push     = r_inflight && !redirect;
   assign w_pop      = out_valid && out_ready;

   assign instr_rd_en   = w_fetch;
   assign instr_rd_addr = r_pc;
   assign out_valid     = w_has_data && !redirect;
   assign out_instr     = w_has_data ? r_q_instr[r_rd_ptr] : '0;
   assign out_addr      = w_has_data ? r_q_addr[r_rd_ptr]  : '0;
   assign count         = r_count;

   // Fetch address, in-flight flag and the address of the outstanding request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_inflight <= 1'b0;
      end else if (redirect) begin
         r_pc       <= w_redirect_pc;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_fetch;
         if (w_fetch) begin
            r_pc     <= r_pc + 32'd4;
            r_req_pc <= r_pc;
         end
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue and drops the response arriving with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (redirect) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are only observable through out_* while count is non-zero.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_addr[r_wr_ptr]  <= r_req_pc;
         r_q_instr[r_wr_ptr] <= instr_rd_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory model returns addr^A5A5_0000 one cycle after each request.
// A negedge monitor checks fetch addresses and every popped entry against an in-order scoreboard.
// Directed sequences cover reset, streaming, full stall, redirects, wrap and asynchronous reset.
module tb_instr_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] SIG      = 32'hA5A5_0000;
   localparam int          CW       = $clog2(DEPTH+1);

   logic          clk           = 1'b0;
   logic          rst           = 1'b1;
   logic          instr_rd_en;
   logic [31:0]   instr_rd_addr;
   logic [31:0]   instr_rd_data = '0;
   logic          redirect      = 1'b0;
   logic [31:0]   redirect_addr = '0;
   logic          out_valid;
   logic          out_ready     = 1'b0;
   logic [31:0]   out_instr;
   logic [31:0]   out_addr;
   logic [CW-1:0] count;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb_q[$];
   logic [31:0] exp_fetch = '0;
   logic [31:0] mon_exp;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_rd_en   (instr_rd_en),
      .instr_rd_addr (instr_rd_addr),
      .instr_rd_data (instr_rd_data),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_addr      (out_addr),
      .count         (count)
   );

   always #5 clk = ~clk;

   // Memory with fixed one-cycle read latency.
   always @(posedge clk) instr_rd_data <= instr_rd_addr ^ SIG;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   task automatic sb_refill(input logic [31:0] base);
      sb_q.delete();
      for (int i = 0; i < 64; i++) sb_q.push_back(base + 32'(4 * i));
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic restart(input logic rdy);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      redirect  = 1'b0;
      out_ready = rdy;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Scoreboard monitor: restart points reload the expected address stream.
   always @(negedge clk) begin
      if (rst || redirect) begin
         chk("idle_rd_en", 32'(instr_rd_en), 32'd0);
         chk("idle_vld", 32'(out_valid), 32'd0);
         exp_fetch = rst ? RESET_PC : (redirect_addr & ~32'h3);
         sb_refill(exp_fetch);
      end else begin
         chk("vld_vs_cnt", 32'(out_valid), 32'(count != '0));
         chk("cnt_bound", 32'(count <= CW'(DEPTH)), 32'd1);
         if (instr_rd_en) begin
            chk("fetch_addr", instr_rd_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (out_valid && out_ready) begin
            mon_exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
            chk("pop_addr", out_addr, mon_exp);
            chk("pop_instr", out_instr, mon_exp ^ SIG);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      #2;
      chk("rst_rd_en", 32'(instr_rd_en), 32'd0);
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_oaddr", out_addr, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_pc", instr_rd_addr, RESET_PC);

      // Streaming with out_ready=1
      restart(1'b1);
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("strm_rd_en", 32'(instr_rd_en), 32'd1);
         chk("strm_rd_addr", instr_rd_addr, RESET_PC + 32'(4 * c));
         chk("strm_vld", 32'(out_valid), 32'(c >= 2));
         if (c >= 2) chk("strm_oaddr", out_addr, RESET_PC + 32'(4 * (c - 2)));
         next_cyc();
      end

      // Fill to DEPTH with out_ready=0, then one pop
      restart(1'b0);
      for (int c = 0; c < 12; c++) begin
         if (c == 8) out_ready = 1'b1;
         if (c == 9) out_ready = 1'b0;
         #1;
         if (c <= 3) begin
            chk("full_rd_en", 32'(instr_rd_en), 32'd1);
            chk("full_rd_addr", instr_rd_addr, 32'(4 * c));
         end
         if (c >= 4 && c <= 8) begin
            chk("full_stall", 32'(instr_rd_en), 32'd0);
            chk("full_hold_pc", instr_rd_addr, 32'h10);
         end
         if (c >= 5 && c <= 8) begin
            chk("full_count", 32'(count), 32'd4);
            chk("full_head", out_addr, 32'h0);
            chk("full_vld", 32'(out_valid), 32'd1);
         end
         if (c == 8) chk("full_instr", out_instr, SIG);
         if (c == 9) begin
            chk("pop_count", 32'(count), 32'd3);
            chk("refetch_en", 32'(instr_rd_en), 32'd1);
            chk("refetch_addr", instr_rd_addr, 32'h10);
            chk("pop_head", out_addr, 32'h4);
         end
         if (c == 10) chk("refetch_stall", 32'(instr_rd_en), 32'd0);
         if (c == 11) chk("refill_count", 32'(count), 32'd4);
         next_cyc();
      end

      // Redirect with 3 queued and one in flight
      restart(1'b0);
      for (int c = 0; c < 9; c++) begin
         if (c == 4) begin
            redirect      = 1'b1;
            redirect_addr = 32'h103;
         end
         if (c == 5) redirect = 1'b0;
         #1;
         if (c == 4) begin
            chk("redir_rd_en", 32'(instr_rd_en), 32'd0);
            chk("redir_vld", 32'(out_valid), 32'd0);
            chk("redir_pre_cnt", 32'(count), 32'd3);
         end
         if (c == 5) begin
            chk("redir_count", 32'(count), 32'd0);
            chk("redir_pc", instr_rd_addr, 32'h100);
            chk("redir_fetch", 32'(instr_rd_en), 32'd1);
         end
         if (c == 6) begin
            chk("redir_stale", 32'(count), 32'd0);
            chk("redir_pc2", instr_rd_addr, 32'h104);
         end
         if (c == 7) begin
            chk("redir_vld2", 32'(out_valid), 32'd1);
            chk("redir_oaddr", out_addr, 32'h100);
            chk("redir_instr", out_instr, 32'h100 ^ SIG);
         end
         if (c == 8) chk("redir_hold", out_addr, 32'h100);
         next_cyc();
      end

      // Push and pop together at count=2 across pointer wrap
      restart(1'b0);
      for (int c = 0; c < 3 + 3 * DEPTH + 3; c++) begin
         if (c == 3) out_ready = 1'b1;
         #1;
         if (c >= 3) begin
            chk("wrap_count", 32'(count), 32'd2);
            chk("wrap_oaddr", out_addr, 32'(4 * (c - 3)));
         end
         next_cyc();
      end

      // Back-to-back redirects
      restart(1'b0);
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            redirect      = 1'b1;
            redirect_addr = 32'h200;
         end
         if (c == 4) redirect_addr = 32'h300;
         if (c == 5) redirect = 1'b0;
         if (c == 7) out_ready = 1'b1;
         #1;
         if (c == 4) chk("dbl_rd_en", 32'(instr_rd_en), 32'd0);
         if (c == 5) begin
            chk("dbl_pc", instr_rd_addr, 32'h300);
            chk("dbl_count", 32'(count), 32'd0);
         end
         if (c >= 7) chk("dbl_oaddr", out_addr, 32'h300 + 32'(4 * (c - 7)));
         next_cyc();
      end

      // Asynchronous reset mid-stream
      restart(1'b0);
      for (int c = 0; c < 4; c++) next_cyc();
      #1;
      chk("arst_pre_cnt", 32'(count), 32'd3);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_vld", 32'(out_valid), 32'd0);
      chk("arst_instr", out_instr, 32'd0);
      chk("arst_oaddr", out_addr, 32'd0);
      chk("arst_rd_en", 32'(instr_rd_en), 32'd0);
      chk("arst_pc", instr_rd_addr, RESET_PC);
      next_cyc();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (c == 0) begin
            chk("arst_fetch", 32'(instr_rd_en), 32'd1);
            chk("arst_pc0", instr_rd_addr, RESET_PC);
         end
         if (c == 1) chk("arst_drop", 32'(count), 32'd0);
         if (c == 2) begin
            chk("arst_vld2", 32'(out_valid), 32'd1);
            chk("arst_head", out_addr, RESET_PC);
            chk("arst_cnt2", 32'(count), 32'd1);
         end
         next_cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
